// File: rtl/clock_pkg.sv
// clock_pkg: shared FSM state, field limits and widths for the time/alarm writer.
package clock_pkg;
  typedef enum logic [1:0] {RUN, SET_HOURS, SET_MINUTES, SET_SECONDS} state_t;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX = 23;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W = 5;
  function automatic logic [1:0] field_of(state_t s);
    return 2'(s);
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-(MAX+1) counter with sync clear to RST_VAL and a same-cycle wrap pulse for chaining.
module mod_counter #(
  parameter int W = 6,
  parameter int MAX = 59,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = inc && count == W'(MAX);
  always_ff @(posedge clk)
    if (clear) count <= W'(RST_VAL);
    else if (inc) count <= wrap ? '0 : count + W'(1);
endmodule

// File: rtl/time_alarm_writer.sv
// time_alarm_writer: running clock plus alarm registers, both editable field-by-field via set/inc buttons.
module time_alarm_writer
  import clock_pkg::*;
#(
  parameter int ALARM_RST_HOURS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             set_btn,
  input  logic             inc_btn,
  input  logic             alarm_mode,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic [SEC_W-1:0] alarm_seconds,
  output logic [MIN_W-1:0] alarm_minutes,
  output logic [HR_W-1:0]  alarm_hours,
  output logic             edit_active,
  output logic [1:0]       edit_field
);
  state_t st, nxt;
  logic target, tick_ok, inc_ok, e_h, e_m, e_s, s_wrap, m_wrap;
  logic [3:0] wrap_unused;
  assign nxt = set_btn ? state_t'(st + 2'd1) : st;
  always_ff @(posedge clk)
    if (reset) begin
      st <= RUN;
      target <= 1'b0;
      edit_active <= 1'b0;
      edit_field <= 2'd0;
    end else begin
      st <= nxt;
      edit_active <= nxt != RUN;
      edit_field <= field_of(nxt);
      if (st == RUN && set_btn) target <= alarm_mode;
    end
  // Ticks are dropped while the time itself is being edited, so the carry chain only ever sees ticks.
  assign tick_ok = tick_1hz && (st == RUN || target);
  assign inc_ok = inc_btn && !set_btn && st != RUN;
  assign e_h = inc_ok && st == SET_HOURS;
  assign e_m = inc_ok && st == SET_MINUTES;
  assign e_s = inc_ok && st == SET_SECONDS;
  mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .clear(reset), .inc(tick_ok || (!target && e_s)),
    .count(seconds), .wrap(s_wrap));
  mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .clear(reset), .inc((tick_ok && s_wrap) || (!target && e_m)),
    .count(minutes), .wrap(m_wrap));
  mod_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk(clk), .clear(reset), .inc((tick_ok && m_wrap) || (!target && e_h)),
    .count(hours), .wrap(wrap_unused[0]));
  mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_asec (
    .clk(clk), .clear(reset), .inc(target && e_s),
    .count(alarm_seconds), .wrap(wrap_unused[1]));
  mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_amin (
    .clk(clk), .clear(reset), .inc(target && e_m),
    .count(alarm_minutes), .wrap(wrap_unused[2]));
  mod_counter #(.W(HR_W), .MAX(HR_MAX), .RST_VAL(ALARM_RST_HOURS)) u_ahr (
    .clk(clk), .clear(reset), .inc(target && e_h),
    .count(alarm_hours), .wrap(wrap_unused[3]));
endmodule

// File: doc/time_alarm_writer.md
TIME_ALARM_WRITER -- requirements
Module: time_alarm_writer

Interface
REQ-001 SHALL have parameter ALARM_RST_HOURS, default 6: alarm hours value loaded at reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick_1hz  input  1  one-cycle pulse, once per second.
REQ-005 SHALL have port set_btn  input  1  one-cycle debounced pulse; advances the edit field.
REQ-006 SHALL have port inc_btn  input  1  one-cycle debounced pulse; increments the field under edit.
REQ-007 SHALL have port alarm_mode  input  1  edit target select: 0 = time, 1 = alarm; sampled only on entry to edit.
REQ-008 SHALL have outputs seconds / minutes / hours  output  6/6/5  current time, registered.
REQ-009 SHALL have outputs alarm_seconds / alarm_minutes / alarm_hours  output  6/6/5  alarm time, registered.
REQ-010 SHALL have port edit_active  output  1  high in any SET state.
REQ-011 SHALL have port edit_field  output  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds.

Function
REQ-012 SHALL implement FSM states RUN, SET_HOURS, SET_MINUTES, SET_SECONDS.
REQ-013 SHALL step RUN->SET_HOURS->SET_MINUTES->SET_SECONDS->RUN, one state per set_btn pulse, otherwise hold.
REQ-014 SHALL latch alarm_mode into an internal target bit on the RUN->SET_HOURS transition; alarm_mode changes mid-edit SHALL be ignored.
REQ-015 SHALL, in a SET state with inc_btn and no set_btn, increment the edited field of the target set by 1, visible the next cycle.
REQ-016 SHALL give set_btn priority over inc_btn when both arrive in the same cycle: state advances, no increment.
REQ-017 SHALL wrap edited fields independently, with no carry: seconds/minutes 59->0, hours 23->0.
REQ-018 SHALL, on tick_1hz, advance time with carry: seconds 59->0 increments minutes, minutes 59->0 increments hours, and 23:59:59->00:00:00; visible next cycle.
REQ-019 SHALL ignore tick_1hz while editing time (target = 0), so the clock is frozen; ticks SHALL NOT be queued.
REQ-020 SHALL apply tick_1hz normally while editing the alarm (target = 1); a tick and an inc in the same cycle both take effect.
REQ-021 SHALL never modify the alarm registers except through edit increments.
REQ-022 SHALL keep all outputs in range at all times: seconds/minutes 0..59, hours 0..23.
REQ-023 SHALL drive edit_active and edit_field as registered decodes of the FSM state (Moore outputs).

Reset
REQ-024 SHALL, on reset high at a clk edge, set state = RUN, target = 0, time = 00:00:00 and alarm = ALARM_RST_HOURS:00:00.
REQ-025 SHALL hold edit_active = 0 and edit_field = 0 during reset.
REQ-026 SHALL let reset override every other input in the same cycle, including mid-edit; any partial edit is discarded to reset values.

Structure
REQ-027 SHALL place in a shared package clock_pkg: the FSM state enum, SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23, and the field widths 6/6/5.
REQ-028 SHALL use one sub-module, mod_counter (parameterized modulus and width; inputs inc and clear; output wrap pulse), for all six fields; time fields chain via the wrap pulse, alarm fields do not chain.
REQ-029 SHALL keep outputs width- and meaning-compatible with the existing display/compare block, so the two connect directly.

Verification
REQ-030 SHALL cover: reset, then 5 ticks -> 00:00:05, alarm 06:00:00, edit_active = 0.
REQ-031 SHALL cover: time preset to 23:59:59 via edit, then one tick -> 00:00:00 the next cycle.
REQ-032 SHALL cover: alarm_mode = 1, set, 3 inc, set, 30 inc, set, set -> alarm 09:30:00, back in RUN, time kept counting throughout.
REQ-033 SHALL cover: alarm_mode = 0, set, then 10 ticks while in SET_HOURS -> time unchanged; 24 inc -> hours wraps to 0.
REQ-034 SHALL cover: set_btn and inc_btn in the same cycle in SET_MINUTES -> state = SET_SECONDS, minutes unchanged.
REQ-035 SHALL cover: reset asserted mid-edit in SET_MINUTES after 7 inc -> RUN, all registers at reset values the next cycle.
